// File: rtl/mips_alu_issue_if.sv
// Issue-stage bus: instruction input, ALU-facing output stage, write-back port and debug view.
// slave = issue stage, master = upstream/ALU/test side.
interface mips_alu_issue_if #(
  parameter int DW   = 8,
  parameter int AW   = 3,
  parameter int NREG = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_alu_op;
  logic [5:0]      in_funct;
  logic [AW-1:0]   in_rs;
  logic [AW-1:0]   in_rt;
  logic [AW-1:0]   in_rd;
  logic            in_wr;
  logic            in_alu_src;
  logic [DW-1:0]   in_imm;

  logic            ex_valid;
  logic            ex_ready;
  logic [DW-1:0]   ex_a;
  logic [DW-1:0]   ex_b;
  logic [3:0]      ex_alu_ctl;
  logic [AW-1:0]   ex_rd;

  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;

  logic            illegal_op;
  logic [NREG-1:0] dbg_busy;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable while valid && !ready.
  modport slave (
    input  in_valid, in_alu_op, in_funct, in_rs, in_rt, in_rd, in_wr, in_alu_src, in_imm,
    output in_ready,
    output ex_valid, ex_a, ex_b, ex_alu_ctl, ex_rd,
    input  ex_ready,
    input  wb_en, wb_addr, wb_data,
    output illegal_op, dbg_busy
  );

  modport master (
    output in_valid, in_alu_op, in_funct, in_rs, in_rt, in_rd, in_wr, in_alu_src, in_imm,
    input  in_ready,
    input  ex_valid, ex_a, ex_b, ex_alu_ctl, ex_rd,
    output ex_ready,
    output wb_en, wb_addr, wb_data,
    input  illegal_op, dbg_busy
  );
endinterface

// File: rtl/mips_alu_issue.sv
// ALU issue stage: decode, 8x8b regfile read with write-back bypass, busy-bit RAW stall, registered ex_* stage.
// Optional MIPS_ISSUE_ILLEGAL_TRAP_EN: drop illegal R-type functs and raise sticky illegal_op.
module mips_alu_issue #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input logic              clk,
  input logic              rst_n,
  mips_alu_issue_if.slave  bus
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  logic [DW-1:0]   r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_ex_valid;
  logic [DW-1:0]   r_ex_a;
  logic [DW-1:0]   r_ex_b;
  logic [3:0]      r_ex_ctl;
  logic [AW-1:0]   r_ex_rd;

  logic [3:0]      w_ctl;
  logic [DW-1:0]   w_a;
  logic [DW-1:0]   w_b;
  logic            w_byp_rs;
  logic            w_byp_rt;
  logic            w_stall;
  logic            w_ready;
  logic            w_accept;
  logic            w_issue;

`ifdef MIPS_ISSUE_ILLEGAL_TRAP_EN
  logic            w_illegal;
  logic            r_illegal;
`endif

  always_comb begin
    w_ctl = CTL_ADD;
`ifdef MIPS_ISSUE_ILLEGAL_TRAP_EN
    w_illegal = 1'b0;
`endif
    case (bus.in_alu_op)
      2'b00: w_ctl = CTL_ADD;
      2'b01: w_ctl = CTL_SUB;
      2'b11: w_ctl = CTL_OR;
      default: begin
        case (bus.in_funct)
          6'b100100: w_ctl = CTL_AND;
          6'b100101: w_ctl = CTL_OR;
          6'b100000: w_ctl = CTL_ADD;
          6'b100010: w_ctl = CTL_SUB;
          6'b101010: w_ctl = CTL_SLT;
          6'b100111: w_ctl = CTL_NOR;
          default: begin
            w_ctl = CTL_ADD;
`ifdef MIPS_ISSUE_ILLEGAL_TRAP_EN
            w_illegal = 1'b1;
`endif
          end
        endcase
      end
    endcase
  end

  // A register being written back this cycle is forwarded and treated as not busy.
  assign w_byp_rs = bus.wb_en && (bus.wb_addr == bus.in_rs) && (bus.in_rs != '0);
  assign w_byp_rt = bus.wb_en && (bus.wb_addr == bus.in_rt) && (bus.in_rt != '0);

  always_comb begin
    w_a = '0;
    w_b = '0;
    if (w_byp_rs)               w_a = bus.wb_data;
    else if (bus.in_rs != '0)   w_a = r_regs[bus.in_rs];
    if (bus.in_alu_src)         w_b = bus.in_imm;
    else if (w_byp_rt)          w_b = bus.wb_data;
    else if (bus.in_rt != '0)   w_b = r_regs[bus.in_rt];
  end

  assign w_stall  = (r_busy[bus.in_rs] && !w_byp_rs) ||
                    (!bus.in_alu_src && r_busy[bus.in_rt] && !w_byp_rt);
  assign w_ready  = !w_stall && (!r_ex_valid || bus.ex_ready);
  assign w_accept = bus.in_valid && w_ready;

`ifdef MIPS_ISSUE_ILLEGAL_TRAP_EN
  assign w_issue  = w_accept && !w_illegal;
`else
  assign w_issue  = w_accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_ctl   <= '0;
      r_ex_rd    <= '0;
    end else if (w_issue) begin
      r_ex_valid <= 1'b1;
      r_ex_a     <= w_a;
      r_ex_b     <= w_b;
      r_ex_ctl   <= w_ctl;
      r_ex_rd    <= bus.in_wr ? bus.in_rd : '0;
    end else if (bus.ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  // Set has priority over a same-edge write-back clear of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (w_issue && bus.in_wr && (bus.in_rd == AW'(i)))
          r_busy[i] <= 1'b1;
        else if (bus.wb_en && (bus.wb_addr == AW'(i)))
          r_busy[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (bus.wb_en && (bus.wb_addr != '0)) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

`ifdef MIPS_ISSUE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_illegal <= 1'b0;
    else if (w_accept && w_illegal)  r_illegal <= 1'b1;
  end
  assign bus.illegal_op = r_illegal;
`else
  assign bus.illegal_op = 1'b0;
`endif

  assign bus.in_ready   = w_ready;
  assign bus.ex_valid   = r_ex_valid;
  assign bus.ex_a       = r_ex_a;
  assign bus.ex_b       = r_ex_b;
  assign bus.ex_alu_ctl = r_ex_ctl;
  assign bus.ex_rd      = r_ex_rd;
  assign bus.dbg_busy   = r_busy;

endmodule

// File: tb/tb_mips_alu_issue.sv
// Directed bench for mips_alu_issue: decode, bypass, RAW stall, backpressure, r0, illegal funct, async reset.
module tb_mips_alu_issue;
  localparam int DW = 8, AW = 3, NREG = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mips_alu_issue_if #(.DW(DW), .AW(AW), .NREG(NREG)) bus ();

  mips_alu_issue #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_alu_op  = 2'b00;
    bus.in_funct   = 6'b0;
    bus.in_rs      = '0;
    bus.in_rt      = '0;
    bus.in_rd      = '0;
    bus.in_wr      = 1'b0;
    bus.in_alu_src = 1'b0;
    bus.in_imm     = '0;
    bus.ex_ready   = 1'b1;
    bus.wb_en      = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [5:0] funct,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic wr,
                        input logic src, input logic [DW-1:0] imm);
    bus.in_valid   = 1'b1;
    bus.in_alu_op  = op;
    bus.in_funct   = funct;
    bus.in_rs      = rs;
    bus.in_rt      = rt;
    bus.in_rd      = rd;
    bus.in_wr      = wr;
    bus.in_alu_src = src;
    bus.in_imm     = imm;
  endtask

  task automatic wb_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    step();
    bus.wb_en   = 1'b0;
  endtask

  logic [5:0] dec_funct [3];
  logic [3:0] dec_ctl   [3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_illegal", bus.illegal_op, 0);
    chk("rst_busy", bus.dbg_busy, 0);
    rst_n = 1'b1;
    settle();
    chk("rst_in_ready", bus.in_ready, 1);

    // R-type AND
    wb_write(3'd1, 8'h01);
    wb_write(3'd2, 8'h03);
    set_op(2'b10, 6'b100100, 3'd1, 3'd2, 3'd4, 1'b1, 1'b0, 8'h00);
    settle();
    chk("and_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("and_ex_valid", bus.ex_valid, 1);
    chk("and_ex_a", bus.ex_a, 8'h01);
    chk("and_ex_b", bus.ex_b, 8'h03);
    chk("and_ctl", bus.ex_alu_ctl, 4'b0000);
    chk("and_rd", bus.ex_rd, 3'd4);
    chk("and_busy", bus.dbg_busy, 8'h10);
    wb_write(3'd4, 8'h44);
    chk("and_busy_clr", bus.dbg_busy, 8'h00);
    chk("and_ex_drain", bus.ex_valid, 0);

    // RAW hazard on r3, resolved by same-cycle write-back bypass
    set_op(2'b00, 6'b0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 8'h00);
    step();
    chk("haz_issue_ctl", bus.ex_alu_ctl, 4'b0010);
    chk("haz_issue_rd", bus.ex_rd, 3'd3);
    set_op(2'b10, 6'b100000, 3'd3, 3'd1, 3'd5, 1'b0, 1'b0, 8'h00);
    settle();
    chk("haz_stall0", bus.in_ready, 0);
    step();
    chk("haz_stall1", bus.in_ready, 0);
    chk("haz_ex_drain", bus.ex_valid, 0);
    bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 8'h22;
    settle();
    chk("haz_bypass_ready", bus.in_ready, 1);
    step();
    bus.wb_en = 1'b0;
    bus.in_valid = 1'b0;
    chk("haz_ex_a", bus.ex_a, 8'h22);
    chk("haz_ex_b", bus.ex_b, 8'h01);
    chk("haz_rd_nowr", bus.ex_rd, 3'd0);
    chk("haz_busy", bus.dbg_busy, 8'h00);

    // Backpressure: op A (ori from stored r3) held while ex_ready=0
    set_op(2'b11, 6'b0, 3'd3, 3'd0, 3'd6, 1'b1, 1'b1, 8'h0F);
    step();
    chk("bp_a_ex_a", bus.ex_a, 8'h22);
    chk("bp_a_ex_b", bus.ex_b, 8'h0F);
    chk("bp_a_ctl", bus.ex_alu_ctl, 4'b0001);
    bus.ex_ready = 1'b0;
    set_op(2'b10, 6'b101010, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_hold_valid", bus.ex_valid, 1);
      chk("bp_hold_a", bus.ex_a, 8'h22);
      chk("bp_hold_b", bus.ex_b, 8'h0F);
      step();
    end
    bus.ex_ready = 1'b1;
    settle();
    chk("bp_release_ready", bus.in_ready, 1);
    step();
    chk("bp_b_ex_a", bus.ex_a, 8'h01);
    chk("bp_b_ex_b", bus.ex_b, 8'h03);
    chk("bp_b_ctl", bus.ex_alu_ctl, 4'b0111);
    chk("bp_busy6", bus.dbg_busy, 8'h40);

    // Immediate operand ignores busy rt; register operand stalls on it
    set_op(2'b01, 6'b0, 3'd1, 3'd6, 3'd0, 1'b0, 1'b1, 8'h0B);
    settle();
    chk("imm_in_ready", bus.in_ready, 1);
    step();
    chk("imm_ctl", bus.ex_alu_ctl, 4'b0110);
    chk("imm_ex_a", bus.ex_a, 8'h01);
    chk("imm_ex_b", bus.ex_b, 8'h0B);
    set_op(2'b10, 6'b100111, 3'd1, 3'd6, 3'd0, 1'b0, 1'b0, 8'h00);
    settle();
    chk("rt_stall", bus.in_ready, 0);
    bus.wb_en = 1'b1; bus.wb_addr = 3'd6; bus.wb_data = 8'h66;
    settle();
    chk("rt_bypass_ready", bus.in_ready, 1);
    step();
    bus.wb_en = 1'b0;
    bus.in_valid = 1'b0;
    chk("nor_ctl", bus.ex_alu_ctl, 4'b1100);
    chk("nor_ex_b", bus.ex_b, 8'h66);
    chk("nor_busy", bus.dbg_busy, 8'h00);

    // r0: write ignored, reads zero, never marked busy
    wb_write(3'd0, 8'hFF);
    set_op(2'b00, 6'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 8'h00);
    step();
    bus.in_valid = 1'b0;
    chk("r0_ex_a", bus.ex_a, 8'h00);
    chk("r0_ex_b", bus.ex_b, 8'h00);
    chk("r0_rd", bus.ex_rd, 3'd0);
    chk("r0_busy", bus.dbg_busy, 8'h00);

    // Remaining R-type decodes
    dec_funct[0] = 6'b100101; dec_ctl[0] = 4'b0001;
    dec_funct[1] = 6'b100010; dec_ctl[1] = 4'b0110;
    dec_funct[2] = 6'b100000; dec_ctl[2] = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      set_op(2'b10, dec_funct[i], 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, 8'h00);
      step();
      chk("dec_ctl", bus.ex_alu_ctl, dec_ctl[i]);
      chk("dec_ex_a", bus.ex_a, 8'h03);
    end
    bus.in_valid = 1'b0;
    step();

    // Illegal funct
    set_op(2'b10, 6'b111111, 3'd1, 3'd2, 3'd7, 1'b1, 1'b0, 8'h00);
    step();
    bus.in_valid = 1'b0;
`ifdef MIPS_ISSUE_ILLEGAL_TRAP_EN
    chk("ill_no_valid", bus.ex_valid, 0);
    chk("ill_flag", bus.illegal_op, 1);
    chk("ill_no_busy", bus.dbg_busy, 8'h00);
    step();
    step();
    chk("ill_sticky", bus.illegal_op, 1);
`else
    chk("ill_valid", bus.ex_valid, 1);
    chk("ill_ctl_add", bus.ex_alu_ctl, 4'b0010);
    chk("ill_rd", bus.ex_rd, 3'd7);
    chk("ill_flag_tied", bus.illegal_op, 0);
    chk("ill_busy7", bus.dbg_busy, 8'h80);
`endif

    // Asynchronous reset while an op is held in the ex stage
    set_op(2'b00, 6'b0, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0, 8'h00);
    step();
    bus.in_valid = 1'b0;
    bus.ex_ready = 1'b0;
    step();
    chk("mid_ex_valid", bus.ex_valid, 1);
    chk("mid_ex_a", bus.ex_a, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", bus.ex_valid, 0);
    chk("arst_ex_a", bus.ex_a, 8'h00);
    chk("arst_busy", bus.dbg_busy, 8'h00);
    chk("arst_illegal", bus.illegal_op, 0);
    step();
    rst_n = 1'b1;
    bus.ex_ready = 1'b1;
    set_op(2'b00, 6'b0, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 8'h00);
    step();
    bus.in_valid = 1'b0;
    chk("arst_reg_a", bus.ex_a, 8'h00);
    chk("arst_reg_b", bus.ex_b, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
